data_ram: RTL and testbench

- Data-side memory responder for the openmips MEM stage. openmips is the initiator; data_ram is the responder and is write-capable.
- Accepts one word read or byte-masked write per transaction. Inserts a configurable number of wait states, then returns a one-cycle ready pulse. openmips stalls its pipeline until that pulse.
- Instantiated next to rom0 in the SoC top level.

---
 rtl/data_ram_pkg.sv | 21 ++
 rtl/data_ram_ram_array.sv | 50 +++++
 rtl/data_ram.sv | 166 ++++++++++++++++
 tb/tb_data_ram.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared definitions for the data-side memory responder: bus constants,
// control encodings and the responder FSM state type.
package data_ram_pkg;

  localparam int          DATA_BUS_W    = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic        RST_ENABLE    = 1'b0;
  localparam int          CNT_W         = 4;
  localparam int          MAX_WAIT      = 15;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'b00,
    DRAM_WAIT = 2'b01,
    DRAM_RESP = 2'b10
  } dram_state_e;

endpackage

// File: rtl/data_ram_ram_array.sv
// Plain word storage built from four byte-wide banks with per-lane write
// enables and a registered word read. No control logic lives here.
module ram_array
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic [3:0]            wr_lane,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_BUS_W-1:0] wr_data,
  output logic [DATA_BUS_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_BUS_W-1:0] rd_word;
  logic [DATA_BUS_W-1:0] rd_data_d;
  logic [DATA_BUS_W-1:0] rd_data_q;

  for (genvar l = 0; l < 4; l++) begin : g_bank
    logic [7:0] bank [DEPTH];

    // Byte lane l is written only when its lane enable is set.
    always_ff @(posedge clk) begin
      if (wr_lane[l]) begin
        bank[addr] <= wr_data[8*l +: 8];
      end
    end

    assign rd_word[8*l +: 8] = bank[addr];
  end

  // Hold the last read word until a new read is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_word;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_ram.sv
// Data-side memory responder for the MEM stage: accepts one word read or
// byte-masked write, waits WAIT_CYCLES cycles, then pulses mem_ready.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready,
  output logic        mem_err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("data_ram: WAIT_CYCLES must be within 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr
    $error("data_ram: ADDR_W must be within 1..29");
  end

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              rd_vld_q, rd_vld_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              in_oor;
  logic              req_we;
  logic              req_oor;
  logic [ADDR_W-1:0] req_idx;
  logic [3:0]        req_sel;
  logic [31:0]       req_wdata;
  logic              go_resp;
  logic              commit;
  logic [3:0]        wr_lane;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              unused_addr_lsb;

  assign in_oor          = |mem_addr[31:ADDR_W+2];
  assign unused_addr_lsb = ^mem_addr[1:0];

  // In IDLE the request is still on the bus (the zero-wait case commits
  // straight from it); afterwards the latched copy is authoritative.
  always_comb begin
    req_we    = we_q;
    req_oor   = oor_q;
    req_idx   = idx_q;
    req_sel   = sel_q;
    req_wdata = wdata_q;
    if (state_q == DRAM_IDLE) begin
      req_we    = mem_we;
      req_oor   = in_oor;
      req_idx   = mem_addr[ADDR_W+1:2];
      req_sel   = mem_sel;
      req_wdata = mem_data_i;
    end
  end

  // The array is touched only on the edge that enters RESP, and never while
  // reset is asserted, so an interrupted write is dropped.
  always_comb begin
    go_resp = ((state_q == DRAM_IDLE) && (mem_ce == CHIP_ENABLE) && (WAIT_CYCLES == 0)) ||
              ((state_q == DRAM_WAIT) && (cnt_q == '0));
    commit  = go_resp && (rst != RST_ENABLE);
    wr_lane = (commit && (req_we == WRITE_ENABLE) && !req_oor) ? req_sel : 4'b0000;
    rd_en   = commit && (req_we == WRITE_DISABLE) && !req_oor;
  end

  // Next-state, wait counter, request latch and registered response flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    oor_d    = oor_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rd_vld_d = 1'b0;
    case (state_q)
      DRAM_IDLE: begin
        if (mem_ce == CHIP_ENABLE) begin
          we_d    = mem_we;
          oor_d   = in_oor;
          idx_d   = mem_addr[ADDR_W+1:2];
          sel_d   = mem_sel;
          wdata_d = mem_data_i;
          if (WAIT_CYCLES == 0) begin
            state_d  = DRAM_RESP;
            ready_d  = 1'b1;
            err_d    = in_oor;
            rd_vld_d = (mem_we == WRITE_DISABLE) && !in_oor;
          end else begin
            state_d = DRAM_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      DRAM_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = DRAM_RESP;
          ready_d  = 1'b1;
          err_d    = oor_q;
          rd_vld_d = (we_q == WRITE_DISABLE) && !oor_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAM_RESP: state_d = DRAM_IDLE;
      default:   state_d = DRAM_IDLE;
    endcase
  end

  // Control state resets; the request latch is pure data and does not.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= DRAM_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
    end
    we_q    <= we_d;
    oor_q   <= oor_d;
    idx_q   <= idx_d;
    sel_q   <= sel_d;
    wdata_q <= wdata_d;
  end

  ram_array #(.ADDR_W(ADDR_W)) u_ram_array (
    .clk     (clk),
    .wr_lane (wr_lane),
    .rd_en   (rd_en),
    .addr    (req_idx),
    .wr_data (req_wdata),
    .rd_data (rd_data)
  );

  assign mem_ready  = ready_q;
  assign mem_err    = err_q;
  assign mem_data_o = rd_vld_q ? rd_data : ZERO_WORD;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: three instances (WAIT_CYCLES 0, 1, 3) driven by
// directed steps plus random traffic, checked against a word/byte model.
module tb_data_ram;

  logic        clk;
  logic        rst;
  logic        ce   [3];
  logic        we   [3];
  logic [31:0] addr [3];
  logic [3:0]  sel  [3];
  logic [31:0] di   [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        err  [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rdy [3];

  logic [31:0] model [3][1024];
  bit          known [3][1024];

  data_ram #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_ce(ce[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_sel(sel[0]), .mem_data_i(di[0]), .mem_data_o(dout[0]),
    .mem_ready(rdy[0]), .mem_err(err[0]));

  data_ram #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .mem_ce(ce[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_sel(sel[1]), .mem_data_i(di[1]), .mem_data_o(dout[1]),
    .mem_ready(rdy[1]), .mem_err(err[1]));

  data_ram #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .mem_ce(ce[2]), .mem_we(we[2]), .mem_addr(addr[2]),
    .mem_sel(sel[2]), .mem_data_i(di[2]), .mem_data_o(dout[2]),
    .mem_ready(rdy[2]), .mem_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic int wc(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k. With b2b set the request is left
  // asserted so the next call starts in the cycle right after the pulse.
  task automatic txn(input int k, input bit w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d,
                     input bit b2b, input bit gap_chk);
    int          lat;
    bit          oor;
    int          idx;
    logic [31:0] merged;
    oor = (a[31:12] != 20'd0);
    idx = int'(a[11:2]);
    @(posedge clk); #1;
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; di[k] = d;
    @(negedge clk);
    chk("ready_before_latency", 32'(rdy[k]), 32'd0);
    lat = 0;
    for (int c = 1; c <= 24 && lat == 0; c++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) lat = c;
    end
    chk("latency", 32'(lat), 32'(wc(k) + 1));
    if (lat != 0) begin
      chk("err_flag", 32'(err[k]), 32'(oor));
      if (gap_chk) chk("b2b_interval", 32'(cyc - last_rdy[k]), 32'(wc(k) + 2));
      last_rdy[k] = cyc;
      if (w) chk("write_resp_data_zero", dout[k], 32'd0);
      else if (oor) chk("oor_read_data_zero", dout[k], 32'd0);
      else if (known[k][idx]) chk("read_data", dout[k], model[k][idx]);
      if (w && !oor) begin
        merged = known[k][idx] ? model[k][idx] : 32'd0;
        for (int b = 0; b < 4; b++)
          if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
        if (s == 4'b1111 || known[k][idx]) begin
          model[k][idx] = merged;
          known[k][idx] = 1'b1;
        end
      end
    end
    if (!b2b || lat == 0) begin
      @(posedge clk); #1;
      ce[k] = 1'b0;
      @(negedge clk);
      chk("ready_after_pulse", 32'(rdy[k]), 32'd0);
      chk("data_after_pulse", dout[k], 32'd0);
    end
  endtask

  initial begin
    bit          seen;
    int          k;
    bit          w;
    logic [31:0] a;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; sel[i] = 4'd0; di[i] = 32'd0;
      last_rdy[i] = 0;
    end

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("idle_ready", 32'(rdy[i]), 32'd0);
        chk("idle_data", dout[i], 32'd0);
        chk("idle_err", 32'(err[i]), 32'd0);
      end
    end

    // Full write/read and byte lanes, WAIT_CYCLES=1
    txn(1, 1'b1, 32'h10, 4'b1111, 32'h1234_5678, 0, 0);
    txn(1, 1'b0, 32'h10, 4'b0000, 32'h0, 0, 0);
    txn(1, 1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, 0, 0);
    txn(1, 1'b0, 32'h10, 4'b0000, 32'h0, 0, 0);
    chk("byte_lane_model", model[1][4], 32'h12BB_56DD);
    txn(1, 1'b1, 32'h14, 4'b0000, 32'hFFFF_FFFF, 0, 0);

    // Out of range
    txn(1, 1'b1, 32'h0, 4'b1111, 32'hCAFE_F00D, 0, 0);
    txn(1, 1'b1, 32'h0000_1000, 4'b1111, 32'hFFFF_FFFF, 0, 0);
    txn(1, 1'b0, 32'h0, 4'b1111, 32'h0, 0, 0);
    txn(1, 1'b0, 32'h0000_1000, 4'b1111, 32'h0, 0, 0);

    // Latency sweep with back-to-back reads
    txn(0, 1'b1, 32'h10, 4'b1111, 32'h0BAD_CAFE, 0, 0);
    txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, 1, 0);
    txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, 1, 1);
    txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, 0, 1);
    txn(2, 1'b1, 32'h10, 4'b1111, 32'h5A5A_A5A5, 0, 0);
    txn(2, 1'b0, 32'h10, 4'b0000, 32'h0, 1, 0);
    txn(2, 1'b0, 32'h10, 4'b0000, 32'h0, 1, 1);
    txn(2, 1'b0, 32'h10, 4'b0000, 32'h0, 0, 1);

    // Reset mid-transaction, WAIT_CYCLES=3
    txn(2, 1'b1, 32'h20, 4'b1111, 32'h0102_0304, 0, 0);
    @(posedge clk); #1;
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; sel[2] = 4'b1111; di[2] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; ce[2] = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    chk("reset_mid_data", dout[2], 32'd0);
    for (int c = 0; c < 6; c++) begin
      if (rdy[2] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("reset_mid_no_ready", 32'(seen), 32'd0);
    txn(2, 1'b0, 32'h20, 4'b0000, 32'h0, 0, 0);
    chk("reset_mid_prior_value", model[2][8], 32'h0102_0304);
    txn(2, 1'b1, 32'h24, 4'b1111, 32'h7777_0001, 0, 0);
    txn(2, 1'b0, 32'h24, 4'b0000, 32'h0, 0, 0);

    // Random traffic
    for (int i = 0; i < 48; i++) begin
      k = int'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
      else
        a = {26'd0, 4'($urandom), 2'($urandom)};
      txn(k, w, a, 4'($urandom), $urandom, 0, 0);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++)
        txn(i, 1'b0, 32'(j * 4), 4'b0000, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
